rc4_engine: RTL
===============

# rc4_engine

Parametrised RC4 core controller: on a start strobe it initialises S, runs key scheduling with a KEY_BYTES-long key, then runs PRGA to decrypt MSG_LEN bytes from the encrypted-message RAM into the decrypted-message RAM. It sits between the start button synchroniser and the three single-port RAMs (s, enc, dec). It replaces the separate init and scramble tasks and their external address/data muxing.

## Interface
- KEY_BYTES, 3: key length in bytes, 1..32
- MSG_LEN, 32: message length in bytes, 1..256
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request strobe
- key  in  8*KEY_BYTES  secret key; byte 0 = most-significant byte (24'h000249 = bytes 00,02,49)
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle completion strobe
- s_addr  out  8  S RAM address
- s_wdata  out  8  S RAM write data
- s_wren  out  1  S RAM write enable
- s_rdata  in  8  S RAM read data
- enc_addr  out  8  encrypted RAM address
- enc_rdata  in  8  encrypted RAM read data
- dec_addr  out  8  decrypted RAM address
- dec_wdata  out  8  decrypted RAM write data
- dec_wren  out  1  decrypted RAM write enable

## Operation
- RAMs: address registered on clk; read data valid in the cycle after the address is presented; a write in cycle N is visible to a read addressed in cycle N+1.
- States: IDLE, INIT, KSA (4 sub-cycles K0..K3), PRGA (6 sub-cycles P0..P5), DONE.
- IDLE: start=1 latches key, clears i, j, k, enters INIT. start while not IDLE ignored.
- INIT: 256 cycles, s_wren=1, s_addr=s_wdata=i, i=0..255.
- KSA, i=0..255, key index kb = i mod KEY_BYTES kept as a wrapping counter (no divider):
  - K0: s_addr=i
  - K1: si=s_rdata; j=j+si+key[kb] (mod 256); s_addr=j
  - K2: sj=s_rdata; write S[i]=sj
  - K3: write S[j]=si; i++ (wraps to 0 after 255 -> PRGA)
- PRGA, i=j=0 on entry, k=0..MSG_LEN-1:
  - P0: i=i+1; s_addr=i+1; enc_addr=k
  - P1: si=s_rdata; j=j+si; s_addr=j+si
  - P2: sj=s_rdata; write S[i]=sj
  - P3: write S[j]=si
  - P4: s_addr=si+sj (mod 256)
  - P5: dec_addr=k, dec_wdata=s_rdata^enc_rdata, dec_wren=1; k++; k=MSG_LEN -> DONE
- i==j swap: both writes carry the same value; S unchanged. Required, no special case.
- DONE: one cycle, done=1, then IDLE.
- All arithmetic 8-bit modulo 256; j not reset between KSA and PRGA except to 0 at PRGA entry.

## Timing
- Reset: busy=0, done=0, s_wren=0, dec_wren=0, all addresses/wdata=0, state IDLE. Reset mid-run aborts immediately (next cycle outputs at reset values); RAM contents undefined.
- start sampled at edge E0: busy high cycles 1..1280+6*MSG_LEN; INIT cycles 1..256; KSA 257..1280; PRGA 1281..1280+6*MSG_LEN; done high on cycle 1281+6*MSG_LEN with busy low.
- Write enables are single-cycle pulses; never both s_wren and dec_wren in one cycle.
- start coincident with done: ignored; new start accepted the following cycle.

## Test plan
- INIT: start -> s_wren high 256 consecutive cycles, s_addr=s_wdata=0,1,...,255.
- Vector: KEY_BYTES=3, key=24'h4B6579 ("Key"), MSG_LEN=9, enc=BB F3 16 E8 D9 40 AF 0A D3 -> dec="Plaintext" (50 6C 61 69 6E 74 65 78 74).
- Keystream: KEY_BYTES=5, key=40'h0102030405, MSG_LEN=8, enc all 00 -> dec=B2 39 63 05 F0 3D C0 27.
- Latency: MSG_LEN=32 -> done exactly 1473 cycles after start edge, one cycle wide; busy 1472 cycles.
- start pulsed at cycle 500 of a run -> ignored, identical dec; second start after done -> identical dec contents.
- rst at cycle 600 (mid-KSA) -> all outputs 0 next cycle; later start completes with correct vector result.

Source files
------------

// File: rtl/rc4_engine_if.sv
// Engine-side bundle: start/busy/done control plus the S, encrypted and decrypted RAM ports.
// The engine is the master; the RAMs and the start source sit on the slave side.
interface rc4_engine_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] s_addr;
  logic [7:0] s_wdata;
  logic       s_wren;
  logic [7:0] s_rdata;
  logic [7:0] enc_addr;
  logic [7:0] enc_rdata;
  logic [7:0] dec_addr;
  logic [7:0] dec_wdata;
  logic       dec_wren;

  modport master (
    input  start, s_rdata, enc_rdata,
    output busy, done, s_addr, s_wdata, s_wren, enc_addr, dec_addr, dec_wdata, dec_wren
  );

  modport slave (
    output start, s_rdata, enc_rdata,
    input  busy, done, s_addr, s_wdata, s_wren, enc_addr, dec_addr, dec_wdata, dec_wren
  );
endinterface

// File: rtl/rc4_engine.sv
// RC4 controller: S init, key schedule, then PRGA decrypt of MSG_LEN bytes (1280+6*MSG_LEN busy cycles).
// No backpressure: RAMs are assumed always ready with one-cycle registered reads.
module rc4_engine #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*KEY_BYTES-1:0] key,
  rc4_engine_if.master           bus
);
  localparam int              KB_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KB_W-1:0] KB_LAST = KB_W'(KEY_BYTES - 1);
  localparam logic [7:0]      K_LAST  = 8'(MSG_LEN - 1);

  typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA, DONE} state_t;

  state_t          state, state_n;
  logic [2:0]      sub, sub_n;
  logic [7:0]      i, i_n, j, j_n, k, k_n, si, si_n, sj, sj_n;
  logic [KB_W-1:0] kb, kb_n;
  logic            key_ld;
  logic [7:0]      key_arr [KEY_BYTES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sub   <= 3'd0;
      i     <= 8'd0;
      j     <= 8'd0;
      k     <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
      kb    <= '0;
    end else begin
      state <= state_n;
      sub   <= sub_n;
      i     <= i_n;
      j     <= j_n;
      k     <= k_n;
      si    <= si_n;
      sj    <= sj_n;
      kb    <= kb_n;
    end
  end

  // Key byte 0 is the most-significant byte of the key port.
  always_ff @(posedge clk) begin
    if (key_ld) begin
      for (int b = 0; b < KEY_BYTES; b++) key_arr[b] <= key[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  always_comb begin
    state_n       = state;
    sub_n         = sub;
    i_n           = i;
    j_n           = j;
    k_n           = k;
    si_n          = si;
    sj_n          = sj;
    kb_n          = kb;
    key_ld        = 1'b0;
    bus.busy      = (state == INIT) || (state == KSA) || (state == PRGA);
    bus.done      = 1'b0;
    bus.s_addr    = 8'd0;
    bus.s_wdata   = 8'd0;
    bus.s_wren    = 1'b0;
    bus.enc_addr  = 8'd0;
    bus.dec_addr  = 8'd0;
    bus.dec_wdata = 8'd0;
    bus.dec_wren  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = INIT;
          sub_n   = 3'd0;
          i_n     = 8'd0;
          j_n     = 8'd0;
          k_n     = 8'd0;
          kb_n    = '0;
          key_ld  = 1'b1;
        end
      end
      INIT: begin
        bus.s_wren  = 1'b1;
        bus.s_addr  = i;
        bus.s_wdata = i;
        i_n         = i + 8'd1;
        if (i == 8'd255) state_n = KSA;
      end
      KSA: begin
        case (sub)
          3'd0: begin
            bus.s_addr = i;
            sub_n      = 3'd1;
          end
          3'd1: begin
            si_n       = bus.s_rdata;
            j_n        = j + bus.s_rdata + key_arr[kb];
            bus.s_addr = j_n;
            sub_n      = 3'd2;
          end
          3'd2: begin
            bus.s_addr  = i;
            bus.s_wdata = bus.s_rdata;
            bus.s_wren  = 1'b1;
            sub_n       = 3'd3;
          end
          3'd3: begin
            bus.s_addr  = j;
            bus.s_wdata = si;
            bus.s_wren  = 1'b1;
            i_n         = i + 8'd1;
            kb_n        = (kb == KB_LAST) ? '0 : kb + 1'b1;
            sub_n       = 3'd0;
            if (i == 8'd255) begin
              state_n = PRGA;
              j_n     = 8'd0;
            end
          end
          default: sub_n = 3'd0;
        endcase
      end
      PRGA: begin
        // Holding enc_addr for the whole byte keeps enc_rdata stable until P5.
        bus.enc_addr = k;
        case (sub)
          3'd0: begin
            i_n        = i + 8'd1;
            bus.s_addr = i + 8'd1;
            sub_n      = 3'd1;
          end
          3'd1: begin
            si_n       = bus.s_rdata;
            j_n        = j + bus.s_rdata;
            bus.s_addr = j_n;
            sub_n      = 3'd2;
          end
          3'd2: begin
            sj_n        = bus.s_rdata;
            bus.s_addr  = i;
            bus.s_wdata = bus.s_rdata;
            bus.s_wren  = 1'b1;
            sub_n       = 3'd3;
          end
          3'd3: begin
            bus.s_addr  = j;
            bus.s_wdata = si;
            bus.s_wren  = 1'b1;
            sub_n       = 3'd4;
          end
          3'd4: begin
            bus.s_addr = si + sj;
            sub_n      = 3'd5;
          end
          3'd5: begin
            bus.dec_addr  = k;
            bus.dec_wdata = bus.s_rdata ^ bus.enc_rdata;
            bus.dec_wren  = 1'b1;
            k_n           = k + 8'd1;
            sub_n         = 3'd0;
            if (k == K_LAST) state_n = DONE;
          end
          default: sub_n = 3'd0;
        endcase
      end
      DONE: begin
        bus.done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
